// File: rtl/ysyx_22050368_ifu_pkg.sv
// ysyx_22050368_ifu_pkg: shared widths, reset PC, NOP encoding and IFU state encodings
package ysyx_22050368_ifu_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h8000_0000;
  localparam logic [ILEN-1:0] NOP = 32'h0000_0013;
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } ifu_state_e;
  function automatic logic [XLEN-1:0] align4(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/ysyx_22050368_if_buf.sv
// ysyx_22050368_if_buf: one-entry pc/inst/err holding register toward decode
module ysyx_22050368_if_buf
  import ysyx_22050368_ifu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            load,
  input  logic [XLEN-1:0] in_pc,
  input  logic [ILEN-1:0] in_inst,
  input  logic            in_err,
  input  logic            ready,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [ILEN-1:0] inst,
  output logic            err
);
  // flush kills the entry; a faulted fetch is replaced by a NOP so decode sees a harmless word
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      pc    <= '0;
      inst  <= '0;
      err   <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= in_pc;
      inst  <= in_err ? NOP : in_inst;
      err   <= in_err;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/ysyx_22050368_ifu.sv
// ysyx_22050368_ifu: instruction fetch stage, one outstanding fetch, redirect flushes the stage
module ysyx_22050368_ifu
  import ysyx_22050368_ifu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_v,
  input  logic            imem_req_rdy,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_v,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            imem_err,
  input  logic            redir_v,
  input  logic [XLEN-1:0] redir_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [ILEN-1:0] if_inst,
  output logic            if_err
);
  ifu_state_e      state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic            drop, drop_n;
  logic            load;
  assign load = (state == S_WAIT) && imem_rsp_v && !drop && !redir_v;
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_REQ;
    else     state <= state_n;
  end
  // next state: a response seen while dropping or redirecting returns straight to REQ
  always_comb begin
    state_n = state;
    unique case (state)
      S_REQ:   state_n = imem_req_rdy ? S_WAIT : S_REQ;
      S_WAIT:  state_n = imem_rsp_v ? ((redir_v || drop) ? S_REQ : S_HOLD) : S_WAIT;
      S_HOLD:  state_n = (redir_v || if_ready) ? S_REQ : S_HOLD;
      default: state_n = S_REQ;
    endcase
  end
  // pc advances on a kept response; drop marks the single response still owed by memory after a redirect
  always_comb begin
    pc_n   = redir_v ? align4(redir_pc) : load ? pc + XLEN'(4) : pc;
    drop_n = redir_v ? ((state == S_REQ && imem_req_rdy) || (state == S_WAIT && !imem_rsp_v))
           : (state == S_WAIT && imem_rsp_v) ? 1'b0 : drop;
  end
  // pc and drop registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc   <= RESET_PC;
      drop <= 1'b0;
    end else begin
      pc   <= pc_n;
      drop <= drop_n;
    end
  end
  // request outputs decoded from state; held low while reset is asserted
  always_comb begin
    imem_req_v = (state == S_REQ) && !rst;
    imem_addr  = pc;
  end
  ysyx_22050368_if_buf u_buf (
    .clk     (clk),
    .rst     (rst),
    .flush   (redir_v),
    .load    (load),
    .in_pc   (pc),
    .in_inst (imem_rdata),
    .in_err  (imem_err),
    .ready   (if_ready),
    .valid   (if_valid),
    .pc      (if_pc),
    .inst    (if_inst),
    .err     (if_err)
  );
endmodule

// File: tb/tb_ysyx_22050368_ifu.sv
// tb_ysyx_22050368_ifu: directed literal checks plus randomized traffic against a transaction-level model
module tb_ysyx_22050368_ifu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_rdy = 1'b0, imem_rsp_v = 1'b0, imem_err = 1'b0;
  logic        redir_v = 1'b0, if_ready = 1'b0;
  logic [31:0] imem_rdata = '0, redir_pc = '0;
  logic        imem_req_v, if_valid, if_err;
  logic [31:0] imem_addr, if_pc, if_inst;

  ysyx_22050368_ifu dut (
    .clk(clk), .rst(rst),
    .imem_req_v(imem_req_v), .imem_req_rdy(imem_req_rdy), .imem_addr(imem_addr),
    .imem_rsp_v(imem_rsp_v), .imem_rdata(imem_rdata), .imem_err(imem_err),
    .redir_v(redir_v), .redir_pc(redir_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst), .if_err(if_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // model: next fetch pc, fetch outstanding, outstanding one is stale, and the word held for decode
  logic [31:0] m_pc, m_bpc, m_binst;
  logic        m_bv, m_berr, m_out, m_stale;
  // memory: one pending request with a random response delay
  logic        mem_busy = 1'b0;
  logic [31:0] mem_addr = '0;
  int          mem_dly = 0;

  function automatic logic [31:0] img(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic exp_req;
    exp_req = !rst && !m_out && !m_bv;
    chk("req_v", imem_req_v, exp_req);
    chk("if_valid", if_valid, m_bv);
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    if (m_bv) begin
      chk("if_pc", if_pc, m_bpc);
      chk("if_inst", if_inst, m_binst);
      chk("if_err", if_err, m_berr);
    end
  endtask

  task automatic model_step();
    logic fire, rsp_here;
    fire     = !rst && !m_out && !m_bv && imem_req_rdy;
    rsp_here = imem_rsp_v && m_out;
    if (rst) begin
      m_pc = 32'h8000_0000; m_out = 0; m_stale = 0;
      m_bv = 0; m_bpc = 0; m_binst = 0; m_berr = 0;
    end else if (redir_v) begin
      m_bv    = 0;
      m_out   = fire || (m_out && !rsp_here);
      m_stale = m_out;
      m_pc    = redir_pc & ~32'd3;
    end else begin
      if (m_bv && if_ready) m_bv = 0;
      if (fire) m_out = 1;
      else if (rsp_here) begin
        m_out = 0;
        if (m_stale) m_stale = 0;
        else begin
          m_bv = 1; m_bpc = m_pc; m_berr = imem_err;
          m_binst = imem_err ? 32'h0000_0013 : imem_rdata;
          m_pc += 4;
        end
      end
    end
  endtask

  task automatic tick();
    logic fire_dut;
    #1;
    fire_dut = imem_req_v && imem_req_rdy;
    model_step();
    if (rst) mem_busy = 0;
    else begin
      if (imem_rsp_v) mem_busy = 0;
      if (fire_dut) begin
        mem_busy = 1; mem_addr = imem_addr; mem_dly = $urandom_range(0, 2);
      end
    end
    @(posedge clk);
    #1;
    check_model();
  endtask

  initial begin
    // reset values
    rst = 1; tick();
    chk("rst if_valid", if_valid, 0);
    chk("rst if_pc", if_pc, 0);
    chk("rst if_inst", if_inst, 0);
    chk("rst if_err", if_err, 0);
    chk("rst req_v", imem_req_v, 0);
    rst = 0; #1;
    chk("first req_v", imem_req_v, 1);
    chk("first addr", imem_addr, 32'h8000_0000);
    // basic fetch, response one cycle after acceptance
    imem_req_rdy = 1; tick();
    imem_req_rdy = 0; imem_rsp_v = 1; imem_rdata = 32'h0050_0093; tick();
    imem_rsp_v = 0;
    chk("t1 valid", if_valid, 1);
    chk("t1 pc", if_pc, 32'h8000_0000);
    chk("t1 inst", if_inst, 32'h0050_0093);
    // decode stalls for five cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2 valid", if_valid, 1);
      chk("t2 inst", if_inst, 32'h0050_0093);
      chk("t2 pc", if_pc, 32'h8000_0000);
      chk("t2 no req", imem_req_v, 0);
    end
    if_ready = 1; tick(); if_ready = 0;
    chk("t1 next addr", imem_addr, 32'h8000_0004);
    chk("t1 next req", imem_req_v, 1);
    // redirect while waiting, stale response one cycle later
    imem_req_rdy = 1; tick();
    imem_req_rdy = 0; redir_v = 1; redir_pc = 32'h8000_0100; tick();
    redir_v = 0; imem_rsp_v = 1; imem_rdata = 32'hDEAD_BEEF; tick();
    imem_rsp_v = 0;
    chk("t3 valid", if_valid, 0);
    chk("t3 no deadbeef", if_inst == 32'hDEAD_BEEF, 0);
    chk("t3 req", imem_req_v, 1);
    chk("t3 addr", imem_addr, 32'h8000_0100);
    // redirect and response in the same cycle
    imem_req_rdy = 1; tick();
    imem_req_rdy = 0; redir_v = 1; redir_pc = 32'h8000_0200; imem_rsp_v = 1; tick();
    redir_v = 0; imem_rsp_v = 0;
    chk("t4 valid", if_valid, 0);
    chk("t4 req", imem_req_v, 1);
    chk("t4 addr", imem_addr, 32'h8000_0200);
    // faulted fetch
    imem_req_rdy = 1; tick();
    imem_req_rdy = 0; imem_rsp_v = 1; imem_err = 1; imem_rdata = 32'h1234_5678; tick();
    imem_rsp_v = 0; imem_err = 0;
    chk("t5 valid", if_valid, 1);
    chk("t5 err", if_err, 1);
    chk("t5 inst", if_inst, 32'h0000_0013);
    chk("t5 pc", if_pc, 32'h8000_0200);
    if_ready = 1; tick(); if_ready = 0;
    chk("t5 next addr", imem_addr, 32'h8000_0204);
    // misaligned redirect target and pc wrap
    redir_v = 1; redir_pc = 32'h8000_0102; tick();
    chk("t6 align", imem_addr, 32'h8000_0100);
    redir_pc = 32'hFFFF_FFFC; tick();
    chk("t6 top addr", imem_addr, 32'hFFFF_FFFC);
    redir_v = 0; imem_req_rdy = 1; tick();
    imem_req_rdy = 0; imem_rsp_v = 1; imem_rdata = 32'h0010_0073; tick();
    imem_rsp_v = 0;
    chk("t6 top pc", if_pc, 32'hFFFF_FFFC);
    if_ready = 1; tick(); if_ready = 0;
    chk("t6 wrap addr", imem_addr, 32'h0000_0000);
    // randomized traffic
    rst = 1; tick(); rst = 0;
    for (int n = 0; n < 4000; n++) begin
      rst          = ($urandom_range(0, 299) == 0);
      redir_v      = ($urandom_range(0, 9) == 0);
      redir_pc     = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      if_ready     = $urandom_range(0, 1) != 0;
      imem_req_rdy = $urandom_range(0, 3) != 0;
      if (mem_busy && mem_dly == 0) begin
        imem_rsp_v = 1; imem_rdata = img(mem_addr); imem_err = ($urandom_range(0, 7) == 0);
      end else begin
        imem_rsp_v = !mem_busy && ($urandom_range(0, 19) == 0);
        imem_rdata = $urandom; imem_err = $urandom_range(0, 1) != 0;
        if (mem_busy) mem_dly--;
      end
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
